// File: rtl/dpram_fifo_ctrl.sv
// Show-ahead stream FIFO controller driving an external simple dual-port RAM
// (1-cycle registered read); a head/skid output stage hides the read latency.
module dpram_fifo_ctrl #(
  parameter int WIDTH        = 32,
  parameter int AWIDTH       = 5,
  parameter int AF_THRESHOLD = 28
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              rd_ready,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic [AWIDTH-1:0] ram_address_a,
  output logic [WIDTH-1:0]  ram_data_a,
  output logic              ram_wren_a,
  output logic [AWIDTH-1:0] ram_address_b,
  input  logic [WIDTH-1:0]  ram_q_b
);

  localparam int              DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_THRESHOLD);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic              af_q, af_d;
  logic [WIDTH-1:0]  head_q, head_d;
  logic [WIDTH-1:0]  skid_q, skid_d;

  logic       clr, push, pop, fetch;
  logic [2:0] pend;

  assign clr      = reset | flush;
  assign wr_ready = (cnt_q != DEPTH_C);
  assign push     = wr_valid & wr_ready & ~clr;
  assign rd_valid = (occ_q != 2'd0);
  assign rd_data  = head_q;
  assign pop      = rd_valid & rd_ready;

  assign ram_wren_a    = push;
  assign ram_address_a = wr_ptr_q;
  assign ram_data_a    = wr_data;
  assign ram_address_b = rd_ptr_q;

  assign count       = cnt_q;
  assign almost_full = af_q;

  // Words already committed to the output stage after this cycle's pop; at most 2 fit.
  assign pend  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign fetch = (ram_cnt_q != '0) && (pend < 3'd2) && !clr;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q + (AWIDTH+1)'(push) - (AWIDTH+1)'(fetch);
    cnt_d     = cnt_q + (AWIDTH+1)'(push) - (AWIDTH+1)'(pop);
    occ_d     = occ_q - 2'(pop) + 2'(infl_q);
    infl_d    = fetch;
    af_d      = (cnt_d >= AF_C);
    head_d    = head_q;
    skid_d    = skid_q;
    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (fetch) rd_ptr_d = rd_ptr_q + 1'b1;
    if (pop) begin
      if (occ_q == 2'd2) begin
        head_d = skid_q;
        if (infl_q) skid_d = ram_q_b;
      end else if (infl_q) begin
        head_d = ram_q_b;
      end
    end else if (infl_q) begin
      if (occ_q == 2'd0) head_d = ram_q_b;
      else               skid_d = ram_q_b;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      cnt_q     <= '0;
      occ_q     <= '0;
      infl_q    <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
      infl_q    <= infl_d;
      af_q      <= af_d;
    end
  end

  // Data registers carry no reset; occ_q alone says which of them hold words.
  always_ff @(posedge clock) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 1-cycle-read dual-port RAM.
module tb_dpram_fifo_ctrl;
  logic        clock = 1'b0;
  logic        reset, flush, wr_valid, wr_ready, rd_valid, rd_ready, almost_full, ram_wren_a;
  logic [31:0] wr_data, rd_data, ram_data_a, ram_q_b;
  logic [5:0]  count;
  logic [4:0]  ram_address_a, ram_address_b;
  logic [31:0] mem [0:31];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dpram_fifo_ctrl #(.WIDTH(32), .AWIDTH(5), .AF_THRESHOLD(28)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .almost_full(almost_full),
    .ram_address_a(ram_address_a), .ram_data_a(ram_data_a), .ram_wren_a(ram_wren_a),
    .ram_address_b(ram_address_b), .ram_q_b(ram_q_b)
  );

  always @(posedge clock) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    ram_q_b <= mem[ram_address_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic single_write();
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 32'hA5A5_0001;
    #1;
    chk("s1_wren", 32'(ram_wren_a), 32'd1);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("s1_cnt_t1", 32'(count), 32'd1);
    chk("s1_rv_t1", 32'(rd_valid), 32'd0);
    tick();
    chk("s1_rv_t2", 32'(rd_valid), 32'd0);
    tick();
    chk("s1_rv_t3", 32'(rd_valid), 32'd1);
    chk("s1_data_t3", rd_data, 32'hA5A5_0001);
    chk("s1_cnt_t3", 32'(count), 32'd1);
    tick();
    chk("s1_rv_t4", 32'(rd_valid), 32'd0);
    chk("s1_cnt_t4", 32'(count), 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    int exp_w, sent, rcv, maxc;
    logic do_push;

    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rv", 32'(rd_valid), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);

    // single write, 3-cycle latency
    single_write();

    // fill to full without reading
    do_reset();
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1; wr_data = 32'(i);
      #1;
      chk("s2_wr_ready", 32'(wr_ready), 32'd1);
      tick();
      chk("s2_count", 32'(count), 32'(i + 1));
      chk("s2_af", 32'(almost_full), 32'((i + 1) >= 28));
    end
    wr_data = 32'hDEAD;
    #1;
    chk("s2_full_ready", 32'(wr_ready), 32'd0);
    chk("s2_full_wren", 32'(ram_wren_a), 32'd0);
    tick();
    chk("s2_full_count", 32'(count), 32'd32);
    chk("s2_full_wren2", 32'(ram_wren_a), 32'd0);
    chk("s2_head", rd_data, 32'd0);

    // full: pop and push requested together -> pop only
    rd_ready = 1'b1;
    #1;
    chk("s3_ready", 32'(wr_ready), 32'd0);
    chk("s3_wren", 32'(ram_wren_a), 32'd0);
    chk("s3_data", rd_data, 32'd0);
    tick();
    rd_ready = 1'b0; wr_data = 32'd32;
    #1;
    chk("s3_count31", 32'(count), 32'd31);
    chk("s3_ready_next", 32'(wr_ready), 32'd1);
    chk("s3_wren_next", 32'(ram_wren_a), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("s3_count32", 32'(count), 32'd32);

    rd_ready = 1'b1;
    exp_w = 1;
    for (int c = 0; c < 200 && exp_w <= 32; c++) begin
      #1;
      if (rd_valid) begin
        chk("s2_drain_data", rd_data, 32'(exp_w));
        exp_w++;
      end
      tick();
    end
    chk("s2_drain_words", 32'(exp_w), 32'd33);
    chk("s2_drain_count", 32'(count), 32'd0);
    rd_ready = 1'b0;

    // streaming with rd_ready toggling
    do_reset();
    sent = 0; rcv = 0; maxc = 0;
    for (int c = 0; c < 1000 && rcv < 100; c++) begin
      wr_valid = (sent < 100);
      wr_data  = 32'(1000 + sent);
      rd_ready = (c % 2 == 0);
      #1;
      do_push = wr_valid & wr_ready;
      if (rd_valid && rd_ready) begin
        chk("s4_data", rd_data, 32'(1000 + rcv));
        rcv++;
      end
      if (int'(count) > maxc) maxc = int'(count);
      tick();
      if (do_push) sent++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("s4_received", 32'(rcv), 32'd100);
    chk("s4_max_count", 32'(maxc), 32'd32);
    chk("s4_end_count", 32'(count), 32'd0);

    // flush with 10 held and a fetch in flight
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_data = 32'(500 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("s5_count10", 32'(count), 32'd10);
    chk("s5_head", rd_data, 32'd500);
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 32'd510;
    tick();
    rd_ready = 1'b0; wr_valid = 1'b0; flush = 1'b1;
    #1;
    chk("s5_count_pre", 32'(count), 32'd10);
    tick();
    flush = 1'b0;
    #1;
    chk("s5_fl_count", 32'(count), 32'd0);
    chk("s5_fl_rv", 32'(rd_valid), 32'd0);
    chk("s5_fl_af", 32'(almost_full), 32'd0);
    chk("s5_fl_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("s5_stale_rv", 32'(rd_valid), 32'd0);
    wr_valid = 1'b1; wr_data = 32'h1234;
    #1;
    chk("s5_wren", 32'(ram_wren_a), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("s5_rv_t1", 32'(rd_valid), 32'd0);
    tick();
    chk("s5_rv_t2", 32'(rd_valid), 32'd0);
    tick();
    chk("s5_rv_t3", 32'(rd_valid), 32'd1);
    chk("s5_data_t3", rd_data, 32'h1234);
    chk("s5_cnt_t3", 32'(count), 32'd1);
    tick();
    chk("s5_rv_t4", 32'(rd_valid), 32'd1);
    chk("s5_cnt_t4", 32'(count), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("s5_rv_end", 32'(rd_valid), 32'd0);
    chk("s5_cnt_end", 32'(count), 32'd0);

    // reset mid-stream together with wr_valid
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 32'(70 + i);
      tick();
    end
    reset = 1'b1; wr_data = 32'd77;
    #1;
    chk("s6_wren_rst", 32'(ram_wren_a), 32'd0);
    tick();
    reset = 1'b0; wr_valid = 1'b0;
    #1;
    chk("s6_count", 32'(count), 32'd0);
    chk("s6_rv", 32'(rd_valid), 32'd0);
    chk("s6_ready", 32'(wr_ready), 32'd1);
    chk("s6_af", 32'(almost_full), 32'd0);
    tick();
    chk("s6_rv_idle", 32'(rd_valid), 32'd0);
    single_write();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
